loba_merge_16_4: RTL
====================

Name: loba_merge_16_4

Overview:
- Inverse of the LOBA 16-bit/4-bit operand splitter: rebuilds an approximate 16-bit operand from its high segment (Xh, kh) and low segment (Xl, kl).
- Two-stage pipelined block with valid/ready handshake.
- Sits after LOBA partial-product and segment datapaths to produce the recombined operand or result.
- Also checks that each incoming segment tuple is well formed and counts the malformed ones.

Parameters:
- W, 16, reconstructed operand width (only 16 supported).
- S, 4, segment width (only 4 supported).
- ERRW, 8, width of the saturating malformed-input counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input tuple valid
- in_ready  out  1  block can accept a tuple
- xh  in  4  high segment
- kh  in  4  leading-one position of high segment (3..15)
- xl  in  4  low segment
- kl  in  4  leading-one position of low segment (0 = absent, else 3..11)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- x_out  out  16  reconstructed value
- err_out  out  1  result came from a malformed tuple
- err_cnt  out  ERRW  saturating count of malformed tuples accepted
- err_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Decided: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: in_ready=1, out_valid=0, x_out=0, err_out=0, err_cnt=0, all pipeline valid flags 0.
- Input transfer: occurs on a cycle with in_valid & in_ready. Output transfer: occurs on a cycle with out_valid & out_ready.
- Stage 1 register (S1) captures:
  - sh = max(kh,3) - 3
  - sl = kl - 3 when kl is in 3..11; otherwise the low segment is suppressed (contributes 0)
  - the malformed flag
- Stage 2 register (S2) holds x_out = (xh << sh) + (xl << sl), computed in 17 bits.
  - If bit 16 is set, x_out saturates to 16'hFFFF and the tuple is flagged malformed.
- Latency: accepted at edge N gives out_valid at edge N+2 when downstream is not stalled.
- Throughput: one tuple per cycle.
- Backpressure:
  - S2 advances when it is empty or out_ready=1.
  - S1 advances when it is empty or S2 advances.
  - in_ready = S1 empty or S1 advances (combinational from out_ready; no skid buffer).
  - A stalled stage holds its data unchanged. out_valid must not drop without a transfer.
- Malformed tuple, when any of:
  - kh < 3
  - kh > 3 and xh[3] == 0
  - kl in {1,2,12..15}
  - kl != 0 and kl > kh-4
  - kl > 3 and xl[3] == 0
  - sum overflow
- Malformed tuples still flow through the pipeline and produce a value, with err_out=1 alongside.
- err_cnt:
  - Increments by 1 when a malformed tuple transfers out, saturating at all-ones.
  - err_clr has priority over a simultaneous increment; the result is 0.
- Reset asserted mid-stream: both stages are flushed and all outputs return to reset values immediately (asynchronous). No partial result may appear after rst_n deasserts.

Optional Feature:
- LOBA_MERGE_ROUND_EN defined: a half-LSB compensation is added in stage 2 to the lowest present segment:
  - if kl >= 4: + (1 << (kl-4))
  - else if kl == 0 and kh >= 4: + (1 << (kh-4))
  - otherwise: + 0
  - Overflow then saturates and flags as above.
- Undefined: pure truncating reconstruction, no compensation adder.

Test Plan:
- xh=9, kh=12, xl=13, kl=5, out_ready=1 → x_out=0x1234 two cycles later, err_out=0; with LOBA_MERGE_ROUND_EN → 0x1236.
- xh=7, kh=3, xl=0, kl=0 → x_out=0x0007, err_out=0, identical with rounding enabled.
- xh=2, kh=2, kl=0 → err_out=1, x_out=0x0002, err_cnt 0→1; 300 such tuples → err_cnt=0xFF; err_clr pulsed together with a malformed output → err_cnt=0.
- Stream of 4 back-to-back tuples, out_ready held 0 for 3 cycles:
  - in_ready drops after 2 tuples are accepted
  - x_out is stable while stalled
  - all 4 results emerge in order once released, with no loss or duplication
- xh=15, kh=15, xl=15, kl=11 → x_out=0xFF00, err_out=0. Separately, kl=12 with kh=15 → err_out=1.
- Reset asserted while both stages are full → out_valid=0 and x_out=0 immediately; first tuple after release appears 2 cycles after acceptance.

Source files
------------

// File: rtl/loba_merge_16_4.sv
// LOBA 16/4 segment merger: rebuilds a 16-bit operand from (xh,kh) and (xl,kl) in a two-stage valid/ready pipeline.
// Optional define LOBA_MERGE_ROUND_EN adds a half-LSB compensation to the lowest present segment.
module loba_merge_16_4 #(
    parameter int unsigned W    = 16,
    parameter int unsigned S    = 4,
    parameter int unsigned ERRW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [S-1:0]    xh,
    input  logic [S-1:0]    kh,
    input  logic [S-1:0]    xl,
    input  logic [S-1:0]    kl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    x_out,
    output logic            err_out,
    output logic [ERRW-1:0] err_cnt,
    input  logic            err_clr
);

    localparam int unsigned SUMW = W + 1;
    localparam int unsigned KW   = S + 1;

    // Pipeline advance conditions; in_ready is combinational from out_ready.
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Stage-1 decode: shift amounts, low-segment presence and tuple sanity.
    logic [S-1:0] sh_c;
    logic [S-1:0] sl_c;
    logic         lo_en_c;
    logic         bad_c;

    always_comb begin
        sh_c    = '0;
        sl_c    = '0;
        lo_en_c = 1'b0;
        bad_c   = 1'b0;

        if (kh >= S'(3)) begin
            sh_c = kh - S'(3);
        end

        lo_en_c = (kl >= S'(3)) && (kl <= S'(11));
        if (lo_en_c) begin
            sl_c = kl - S'(3);
        end

        if (kh < S'(3)) begin
            bad_c = 1'b1;
        end
        if ((kh > S'(3)) && !xh[S-1]) begin
            bad_c = 1'b1;
        end
        if ((kl == S'(1)) || (kl == S'(2)) || (kl >= S'(12))) begin
            bad_c = 1'b1;
        end
        // kl > kh-4 evaluated without underflow.
        if ((kl != '0) && ((KW'(kl) + KW'(4)) > KW'(kh))) begin
            bad_c = 1'b1;
        end
        if ((kl > S'(3)) && !xl[S-1]) begin
            bad_c = 1'b1;
        end
    end

`ifdef LOBA_MERGE_ROUND_EN
    logic         rnd_en_c;
    logic [S-1:0] rnd_sh_c;
    logic         s1_rnd_en;
    logic [S-1:0] s1_rnd_sh;

    always_comb begin
        rnd_en_c = 1'b0;
        rnd_sh_c = '0;
        if (kl >= S'(4)) begin
            rnd_en_c = 1'b1;
            rnd_sh_c = kl - S'(4);
        end else if ((kl == '0) && (kh >= S'(4))) begin
            rnd_en_c = 1'b1;
            rnd_sh_c = kh - S'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rnd_en <= 1'b0;
            s1_rnd_sh <= '0;
        end else if (s1_adv && in_valid) begin
            s1_rnd_en <= rnd_en_c;
            s1_rnd_sh <= rnd_sh_c;
        end
    end
`endif

    // Stage-1 register.
    logic [S-1:0] s1_xh;
    logic [S-1:0] s1_xl;
    logic [S-1:0] s1_sh;
    logic [S-1:0] s1_sl;
    logic         s1_lo_en;
    logic         s1_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_xh    <= '0;
            s1_xl    <= '0;
            s1_sh    <= '0;
            s1_sl    <= '0;
            s1_lo_en <= 1'b0;
            s1_err   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_xh    <= xh;
                s1_xl    <= xl;
                s1_sh    <= sh_c;
                s1_sl    <= sl_c;
                s1_lo_en <= lo_en_c;
                s1_err   <= bad_c;
            end
        end
    end

    // Stage-2 datapath: 17-bit sum so a carry out can be detected and saturated.
    logic [SUMW-1:0] hi_c;
    logic [SUMW-1:0] lo_c;
    logic [SUMW-1:0] rnd_c;
    logic [SUMW-1:0] sum_c;

    always_comb begin
        hi_c  = SUMW'(s1_xh) << s1_sh;
        lo_c  = '0;
        rnd_c = '0;
        if (s1_lo_en) begin
            lo_c = SUMW'(s1_xl) << s1_sl;
        end
`ifdef LOBA_MERGE_ROUND_EN
        if (s1_rnd_en) begin
            rnd_c = SUMW'(1) << s1_rnd_sh;
        end
`endif
        sum_c = hi_c + lo_c + rnd_c;
    end

    // Stage-2 register drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x_out     <= '0;
            err_out   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                x_out   <= sum_c[SUMW-1] ? {W{1'b1}} : sum_c[W-1:0];
                err_out <= s1_err || sum_c[SUMW-1];
            end
        end
    end

    // Saturating malformed-output counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && err_out && (err_cnt != {ERRW{1'b1}})) begin
            err_cnt <= err_cnt + ERRW'(1);
        end
    end

endmodule
